// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: 4-channel rising-edge event queue with round-robin offer and drop accounting
module edge_event_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       L,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [1:0]       ev_id,
  output logic             busy,
  output logic [3:0]       overflow,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int SW = CNT_W + 3;
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_n;
  logic [3:0] L_q, pending, rise, clr, drop;
  logic [1:0] ptr, sel;
  logic hs;
  logic [2:0] ndrop;
  logic [SW-1:0] sum;
  assign rise = L & ~L_q;
  assign hs = state == OFFER && ev_ready;
  assign clr = hs ? 4'b0001 << ev_id : 4'b0000;
  assign drop = rise & pending & ~clr;
  assign ev_valid = state == OFFER;
  assign busy = |pending;
  assign ndrop = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
  assign sum = SW'(drop_cnt) + SW'(ndrop);
  always_comb begin
    sel = ptr;
    for (int k = 4; k >= 1; k--)
      if (pending[ptr + 2'(k)]) sel = ptr + 2'(k);
  end
  always_comb begin
    state_n = state == IDLE ? (busy ? OFFER : IDLE) : (ev_ready ? IDLE : OFFER);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    L_q <= L;
    if (reset) begin
      pending  <= '0;
      ptr      <= 2'd3;
      overflow <= '0;
      drop_cnt <= '0;
      ev_id    <= '0;
    end else begin
      pending  <= (pending & ~clr) | rise;
      overflow <= overflow | drop;
      drop_cnt <= sum > SW'({CNT_W{1'b1}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      if (state == IDLE && busy) ev_id <= sel;
      if (hs) ptr <= ev_id;
    end
  end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic ev_ready = 0;
  logic [3:0] L = '0;
  logic ev_valid, busy;
  logic [1:0] ev_id;
  logic [3:0] overflow;
  logic [7:0] drop_cnt;
  logic d2_valid, d2_busy;
  logic [1:0] d2_id;
  logic [3:0] d2_ovf;
  logic [1:0] d2_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int nv;
  edge_event_arbiter dut (
    .clk(clk), .reset(reset), .L(L), .ev_ready(ev_ready), .ev_valid(ev_valid),
    .ev_id(ev_id), .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt)
  );
  edge_event_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .L(L), .ev_ready(ev_ready), .ev_valid(d2_valid),
    .ev_id(d2_id), .busy(d2_busy), .overflow(d2_ovf), .drop_cnt(d2_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic [3:0] l);
    L = l;
    step();
  endtask
  task automatic do_reset(input logic [3:0] l);
    reset = 1;
    L = l;
    step();
    step();
    reset = 0;
  endtask
  initial begin
    ev_ready = 1;
    reset = 1;
    L = '0;
    step();
    step();
    chk("rst_valid", ev_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", drop_cnt, 0);
    chk("rst_id", ev_id, 0);
    reset = 0;
    step();
    drv(4'b0100);
    chk("t1_busy", busy, 1);
    chk("t1_idle", ev_valid, 0);
    step();
    chk("t1_valid", ev_valid, 1);
    chk("t1_id", ev_id, 2);
    nv = 0;
    repeat (6) begin
      step();
      nv += int'(ev_valid);
    end
    chk("t1_once", nv, 0);
    do_reset(4'b0000);
    ev_ready = 1;
    drv(4'b1111);
    for (int i = 0; i < 4; i++) begin
      chk("t2_gap", ev_valid, 0);
      step();
      chk("t2_valid", ev_valid, 1);
      chk("t2_id", ev_id, i);
      step();
    end
    chk("t2_busy", busy, 0);
    chk("t2_end", ev_valid, 0);
    do_reset(4'b0000);
    ev_ready = 0;
    drv(4'b0010);
    drv(4'b0000);
    drv(4'b0010);
    chk("t3_valid", ev_valid, 1);
    chk("t3_id", ev_id, 1);
    chk("t3_ovf", overflow, 4'b0010);
    chk("t3_cnt", drop_cnt, 1);
    step();
    step();
    chk("t3_hold_valid", ev_valid, 1);
    chk("t3_hold_id", ev_id, 1);
    ev_ready = 1;
    nv = 0;
    repeat (5) begin
      nv += int'(ev_valid);
      step();
    end
    chk("t3_events", nv, 1);
    chk("t3_busy", busy, 0);
    chk("t3_ovf_sticky", overflow, 4'b0010);
    do_reset(4'b0000);
    ev_ready = 1;
    drv(4'b1000);
    drv(4'b0000);
    chk("t4_valid", ev_valid, 1);
    chk("t4_id", ev_id, 3);
    drv(4'b1000);
    chk("t4_setwins", busy, 1);
    chk("t4_gap", ev_valid, 0);
    step();
    chk("t4_again", ev_valid, 1);
    chk("t4_again_id", ev_id, 3);
    chk("t4_cnt", drop_cnt, 0);
    chk("t4_ovf", overflow, 0);
    ev_ready = 0;
    do_reset(4'b0101);
    nv = 0;
    repeat (5) begin
      step();
      nv += int'(ev_valid);
    end
    chk("t5_noevent", nv, 0);
    chk("t5_busy", busy, 0);
    drv(4'b0000);
    drv(4'b0001);
    step();
    chk("t5_offer", ev_valid, 1);
    chk("t5_offer_id", ev_id, 0);
    drv(4'b0000);
    drv(4'b0001);
    chk("t5_ovf", overflow, 4'b0001);
    chk("t5_cnt", drop_cnt, 1);
    reset = 1;
    step();
    chk("t5_rst_valid", ev_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ovf", overflow, 0);
    chk("t5_rst_cnt", drop_cnt, 0);
    chk("t5_rst_id", ev_id, 0);
    reset = 0;
    nv = 0;
    repeat (5) begin
      step();
      nv += int'(ev_valid);
    end
    chk("t5_release", nv, 0);
    do_reset(4'b0000);
    ev_ready = 0;
    drv(4'b0001);
    for (int i = 0; i < 5; i++) begin
      drv(4'b0000);
      drv(4'b0001);
      if (i == 2) begin
        chk("t6_cnt3", drop_cnt, 3);
        chk("t6_sat3", d2_cnt, 3);
      end
    end
    chk("t6_cnt5", drop_cnt, 5);
    chk("t6_sat5", d2_cnt, 3);
    drv(4'b0000);
    drv(4'b1111);
    chk("t6_cnt6", drop_cnt, 6);
    drv(4'b0000);
    drv(4'b1111);
    chk("t6_multi", drop_cnt, 10);
    chk("t6_sat_hold", d2_cnt, 3);
    chk("t6_ovf", overflow, 4'b1111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the saturating drop counter.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port L  input  4  level inputs, one per channel 0..3, synchronous to clk.
REQ-005 SHALL have port ev_ready  input  1  consumer accepts the offered event.
REQ-006 SHALL have port ev_valid  output  1  event offered on ev_id.
REQ-007 SHALL have port ev_id  output  2  channel index of the offered event.
REQ-008 SHALL have port busy  output  1  OR of all pending flags.
REQ-009 SHALL have port overflow  output  4  sticky per-channel flag, set when an edge was dropped.
REQ-010 SHALL have port drop_cnt  output  CNT_W  saturating total count of dropped edges.

Function
REQ-011 SHALL hold a registered copy L_q of L; rise[i] = L[i] & ~L_q[i] in the same cycle L[i] first reads high.
REQ-012 SHALL keep one pending flag per channel; rise[i] sets pending[i] at the next clock edge.
REQ-013 SHALL use FSM states IDLE and OFFER; ev_valid = 1 only in OFFER.
REQ-014 IDLE: if any pending, SHALL choose the first pending channel searching round-robin from ptr+1 (mod 4), latch it into ev_id, and enter OFFER next cycle; otherwise stay in IDLE.
REQ-015 OFFER: ev_id and ev_valid SHALL stay stable while ev_ready = 0.
REQ-016 OFFER with ev_ready = 1 (handshake) SHALL clear pending[ev_id], load ptr <= ev_id, and return to IDLE; maximum throughput is one event per 2 cycles.
REQ-017 Edges arriving during OFFER SHALL only set pending flags and SHALL NOT change ev_id.
REQ-018 rise[i] in the handshake cycle for channel i SHALL leave pending[i] = 1 (set wins over clear), with no drop.
REQ-019 rise[i] while pending[i] = 1 and not being cleared that cycle SHALL count as dropped: overflow[i] <= 1, and drop_cnt increments by 1.
REQ-020 drop_cnt SHALL saturate at 2^CNT_W-1; simultaneous drops on k channels SHALL add k, clipped at saturation.
REQ-021 ev_ready while in IDLE SHALL be ignored.
REQ-022 busy SHALL be combinational OR of the pending flags.

Reset
REQ-023 With reset = 1 at a clock edge: state <= IDLE, pending <= 0, ptr <= 3 (channel 0 has first priority), overflow <= 0, drop_cnt <= 0, ev_id <= 0.
REQ-024 During reset, L_q SHALL load L each cycle; a level already high at reset release SHALL NOT generate an event.
REQ-025 Reset asserted mid-OFFER SHALL drop the in-flight event: ev_valid = 0 from the next edge, with no drop counted.
REQ-026 Outputs SHALL be ev_valid = 0, busy = 0, overflow = 0, drop_cnt = 0 from the first edge with reset = 1.

Verification
REQ-027 Single edge: with ev_ready = 1, L[2] 0->1 and held -> ev_valid for exactly 1 cycle with ev_id = 2, 2 cycles after the rise; no further event while L[2] stays high.
REQ-028 Round-robin: L = 4'b1111 rises in one cycle, with ev_ready = 1 -> ev_id sequence 0,1,2,3, each event separated by 1 IDLE cycle.
REQ-029 Backpressure/drop: ev_ready = 0, L[1] pulses 0->1->0->1 -> ev_id = 1 held stable, overflow = 4'b0010, drop_cnt = 1; after ev_ready = 1, exactly one event, then busy = 0.
REQ-030 Set-wins: L[3] rises in the same cycle as the handshake of ev_id = 3 -> a second event with ev_id = 3 follows, and drop_cnt is unchanged.
REQ-031 Reset: L = 4'b0101 high through reset release -> no event; reset asserted during OFFER -> ev_valid = 0 next cycle, and all counters and flags are 0.
REQ-032 Saturation with CNT_W = 2: 5 drops -> drop_cnt = 3 and holds.
